// File: rtl/ula_seq.sv
// ============================================================================
// ula_seq : registered ALU with an iterative shift-add unsigned multiply
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ula_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             fov,
  output logic             fz,
  output logic             fn
);

  localparam int              c_msb  = WIDTH - 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [2*WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]     r_prod;
  logic [WIDTH-1:0]       r_mplier;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_s;
  logic                   r_fov;
  logic                   r_fz;
  logic                   r_fn;
  logic                   r_done;

  logic                   w_load;
  logic                   w_mul_go;
  logic [WIDTH-1:0]       w_res;
  logic                   w_res_ov;
  logic [2*WIDTH-1:0]     w_prod_next;
  logic [WIDTH-1:0]       w_sum;
  logic [WIDTH-1:0]       w_diff;
  logic                   w_add_ov;
  logic                   w_sub_ov;

  assign w_sum       = a + b;
  assign w_diff      = a - b;
  assign w_add_ov    = (a[c_msb] == b[c_msb]) && (w_sum[c_msb]  != a[c_msb]);
  assign w_sub_ov    = (a[c_msb] != b[c_msb]) && (w_diff[c_msb] != a[c_msb]);
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_mul_go     = 1'b0;
    w_res        = '0;
    w_res_ov     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (sel == 3'b011) begin
            w_state_next = S_MUL;
            w_mul_go     = 1'b1;
          end else begin
            w_load = 1'b1;
            case (sel)
              3'b000:  w_res = a & b;
              3'b001:  w_res = a | b;
              3'b010:  begin w_res = w_sum;  w_res_ov = w_add_ov; end
              3'b110:  begin w_res = w_diff; w_res_ov = w_sub_ov; end
              3'b100:  w_res = a & ~b;
              3'b101:  w_res = a | ~b;
              // Sign of the difference corrected by overflow gives a true signed compare
              3'b111:  w_res = {{(WIDTH-1){1'b0}}, w_diff[c_msb] ^ w_sub_ov};
              default: w_res = '0;
            endcase
          end
        end
      end
      S_MUL: begin
        if (r_cnt == c_last) begin
          w_state_next = S_IDLE;
          w_load       = 1'b1;
          w_res        = w_prod_next[WIDTH-1:0];
          w_res_ov     = |w_prod_next[2*WIDTH-1:WIDTH];
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_s      <= '0;
      r_fov    <= 1'b0;
      r_fz     <= 1'b0;
      r_fn     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_load;
      if (w_load) begin
        r_s   <= w_res;
        r_fov <= w_res_ov;
        r_fz  <= (w_res == '0);
        r_fn  <= w_res[c_msb];
      end
      if (w_mul_go) begin
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_prod   <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_MUL) begin
        // One multiplier bit per cycle, LSB first
        r_prod   <= w_prod_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (r_state == S_MUL);
  assign done = r_done;
  assign s    = r_s;
  assign fov  = r_fov;
  assign fz   = r_fz;
  assign fn   = r_fn;

endmodule

`default_nettype wire

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised, registered successor to the 32-bit combinational ALU `ula`.
- Keeps the same opcode map and flag set. Generalises the width and registers every output.
- Adds an iterative unsigned multiply with a start/busy/done handshake.
- Sits between the register file operand latches and the writeback stage of the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH+1), multiply iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low. Clears all state immediately.
- start  input  1  request; sampled only when busy=0.
- sel  input  3  opcode, latched at acceptance.
- a  input  WIDTH  operand A, latched at acceptance.
- b  input  WIDTH  operand B, latched at acceptance.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse; s and flags valid from this cycle onward.
- s  output  WIDTH  result; holds until the next done.
- fov  output  1  overflow flag.
- fz  output  1  zero flag (s == 0).
- fn  output  1  negative flag (s[WIDTH-1]).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, s, fov, fz, fn all 0; counter 0. Effective mid-multiply, where the operation is discarded.
- Opcode map:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB (a-b)
  - 100 a AND ~b
  - 101 a OR ~b
  - 111 SLT
  - 011 MUL (unsigned, low WIDTH bits)
- Acceptance: rising edge with start=1 and busy=0. Start with busy=1 is ignored, with no queuing.
- States:
  - IDLE: accepts requests.
  - MUL: iterating, busy=1.
- Single-cycle ops (all except 011):
  - Accepted at edge k: s and flags are written at edge k, and done=1 during cycle k+1. State stays IDLE.
  - Back-to-back starts are accepted every cycle; done stays high for consecutive results.
- MUL:
  - At acceptance edge k: latch a and b, clear the 2*WIDTH-bit product accumulator, set counter=0, go to MUL, set busy=1.
  - Each edge in MUL: shift-add on one multiplier bit (LSB first), counter+1.
  - At the edge where counter reaches WIDTH-1 → WIDTH: write s = product[WIDTH-1:0], write flags, set busy=0, assert done, go to IDLE.
  - Total: done high in cycle k+WIDTH+1 (WIDTH edges in MUL). A new start is accepted on the edge following done.
- Arithmetic: all results truncated to WIDTH bits; any carry-out is discarded, with no carry flag.
- fov:
  - ADD: a[W-1]==b[W-1] && s[W-1]!=a[W-1].
  - SUB: a[W-1]!=b[W-1] && s[W-1]!=a[W-1].
  - MUL: product[2W-1:W] != 0.
  - Logic ops and SLT: 0.
- SLT: s = 1 if a<b signed, else 0. Computed as the sign of (a-b) XOR the SUB overflow, so it is correct on overflow. fn=0 for SLT.
- fz and fn are always derived from the written s.
- done: exactly one cycle per accepted op, never asserted without a prior acceptance. busy is never high in the same cycle as done.
- Undefined sel cannot occur; all 8 codes are defined.

Test Plan:
- WIDTH=32, ADD a=7FFFFFFF b=00000001 → done after 1 cycle; s=80000000, fov=1, fn=1, fz=0.
- WIDTH=32, SUB a=80000000 b=00000001 → s=7FFFFFFF, fov=1, fn=0. SLT a=80000000 b=7FFFFFFF → s=00000001, fov=0.
- WIDTH=32, MUL a=00010000 b=00010000:
  - busy high for 32 cycles; done in cycle 33; s=00000000, fz=1, fov=1.
  - A start issued during busy is ignored: no extra done, s unchanged.
- WIDTH=8, MUL a=0F b=0D → done after 8 cycles, s=C3, fov=0, fn=1. Back-to-back AND FF&0F then OR 00|00 → consecutive done cycles, s=0F then 00 (fz=1).
- WIDTH=32, reset asserted asynchronously 5 cycles into a MUL → busy, done, s and flags all 0 immediately. After release, AND FFFF0000 & ~0000FFFF (sel=100) → s=FFFF0000, fn=1.
